// File: rtl/itlb_4kb_array.sv
// Set-associative ITLB storage for 4KB pages: registered lookup, PTW fill with
// tree-PLRU replacement, and SFENCE.VMA invalidation across all sets at once.

module itlb_4KB_index_hash #(
  parameter int IDX_W = 3,
  parameter int VPN_W = 20
) (
  input  logic [VPN_W-1:0] vpn_i,
  output logic [IDX_W-1:0] idx_o
);
  assign idx_o = vpn_i[IDX_W-1:0] ^ vpn_i[2*IDX_W-1:IDX_W];
endmodule

module itlb_4kb_array #(
  parameter int ITLB_4KBPAGE_INDEX_WIDTH = 3,
  parameter int ITLB_4KBPAGE_ASSOC       = 2,
  parameter int VPN_WIDTH                = 20,
  parameter int PPN_WIDTH                = 22,
  parameter int ASID_WIDTH               = 9
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  req_valid,
  input  logic [ASID_WIDTH-1:0] req_ASID,
  input  logic [VPN_WIDTH-1:0]  req_VPN,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [PPN_WIDTH-1:0]  resp_PPN,
  output logic [7:0]            resp_flags,
  input  logic                  fill_valid,
  input  logic [ASID_WIDTH-1:0] fill_ASID,
  input  logic [VPN_WIDTH-1:0]  fill_VPN,
  input  logic [PPN_WIDTH-1:0]  fill_PPN,
  input  logic [7:0]            fill_flags,
  input  logic                  sfence_valid,
  input  logic                  sfence_all_ASID,
  input  logic                  sfence_all_VPN,
  input  logic [ASID_WIDTH-1:0] sfence_ASID,
  input  logic [VPN_WIDTH-1:0]  sfence_VPN
);
  localparam int IW    = ITLB_4KBPAGE_INDEX_WIDTH;
  localparam int SETS  = 2 ** IW;
  localparam int ASSOC = ITLB_4KBPAGE_ASSOC;
  localparam int WAY_W = $clog2(ASSOC);
  localparam int G_BIT = 5;

  logic                  valid_q [SETS][ASSOC];
  logic                  valid_d [SETS][ASSOC];
  logic [ASID_WIDTH-1:0] asid_q  [SETS][ASSOC];
  logic [VPN_WIDTH-1:0]  vpn_q   [SETS][ASSOC];
  logic [PPN_WIDTH-1:0]  ppn_q   [SETS][ASSOC];
  logic [7:0]            flags_q [SETS][ASSOC];
  logic [ASSOC-2:0]      plru_q  [SETS];
  logic [ASSOC-2:0]      plru_d  [SETS];

  logic                 resp_valid_q, resp_hit_q;
  logic [PPN_WIDTH-1:0] resp_ppn_q;
  logic [7:0]           resp_flags_q;

  logic [IW-1:0]    req_idx, fill_idx;
  logic             lk_hit;
  logic [WAY_W-1:0] lk_way;
  logic             fill_en, fl_match, fl_free;
  logic [WAY_W-1:0] fl_match_way, fl_free_way, fl_way;

  itlb_4KB_index_hash #(.IDX_W(IW), .VPN_W(VPN_WIDTH)) u_req_hash (
    .vpn_i(req_VPN), .idx_o(req_idx)
  );
  itlb_4KB_index_hash #(.IDX_W(IW), .VPN_W(VPN_WIDTH)) u_fill_hash (
    .vpn_i(fill_VPN), .idx_o(fill_idx)
  );

  // Heap-ordered tree: node n lives at bit n-1; a 0 bit points the victim to the lower half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [ASSOC-2:0] bits);
    int node;
    node = 1;
    for (int l = 0; l < WAY_W; l++) node = node * 2 + int'(bits[node-1]);
    return WAY_W'(node - ASSOC);
  endfunction

  function automatic logic [ASSOC-2:0] plru_touch(input logic [ASSOC-2:0] bits,
                                                  input logic [WAY_W-1:0] way);
    int   node;
    logic dir;
    plru_touch = bits;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      dir = way[WAY_W-1-l];
      plru_touch[node-1] = ~dir;
      node = node * 2 + int'(dir);
    end
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (valid_q[req_idx][w] && vpn_q[req_idx][w] == req_VPN &&
          (flags_q[req_idx][w][G_BIT] || asid_q[req_idx][w] == req_ASID)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  // Dedup treats a global entry (old or new) as matching any ASID with the same VPN.
  always_comb begin
    fl_match     = 1'b0;
    fl_match_way = '0;
    fl_free      = 1'b0;
    fl_free_way  = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (valid_q[fill_idx][w] && vpn_q[fill_idx][w] == fill_VPN &&
          (flags_q[fill_idx][w][G_BIT] || fill_flags[G_BIT] ||
           asid_q[fill_idx][w] == fill_ASID)) begin
        fl_match     = 1'b1;
        fl_match_way = WAY_W'(w);
      end
      if (!valid_q[fill_idx][w]) begin
        fl_free     = 1'b1;
        fl_free_way = WAY_W'(w);
      end
    end
    fl_way  = fl_match ? fl_match_way : (fl_free ? fl_free_way : plru_victim(plru_q[fill_idx]));
    fill_en = fill_valid && !sfence_valid;
  end

  always_comb begin
    plru_d = plru_q;
    if (req_valid && lk_hit) plru_d[req_idx] = plru_touch(plru_d[req_idx], lk_way);
    if (fill_en)             plru_d[fill_idx] = plru_touch(plru_d[fill_idx], fl_way);
  end

  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < ASSOC; w++) begin
        valid_d[s][w] = valid_q[s][w];
        if (sfence_valid) begin
          if ((sfence_all_VPN || vpn_q[s][w] == sfence_VPN) &&
              (sfence_all_ASID || (asid_q[s][w] == sfence_ASID && !flags_q[s][w][G_BIT])))
            valid_d[s][w] = 1'b0;
        end else if (fill_en && fill_idx == IW'(s) && fl_way == WAY_W'(w)) begin
          valid_d[s][w] = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < ASSOC; w++) valid_q[s][w] <= 1'b0;
      end
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_ppn_q   <= '0;
      resp_flags_q <= '0;
    end else begin
      valid_q      <= valid_d;
      plru_q       <= plru_d;
      resp_valid_q <= req_valid;
      resp_hit_q   <= req_valid && lk_hit;
      resp_ppn_q   <= (req_valid && lk_hit) ? ppn_q[req_idx][lk_way] : '0;
      resp_flags_q <= (req_valid && lk_hit) ? flags_q[req_idx][lk_way] : '0;
    end
  end

  // NOTE: entry payload has no reset; valid bits gate every use, so it never needs clearing.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      asid_q[fill_idx][fl_way]  <= fill_ASID;
      vpn_q[fill_idx][fl_way]   <= fill_VPN;
      ppn_q[fill_idx][fl_way]   <= fill_PPN;
      flags_q[fill_idx][fl_way] <= fill_flags;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_PPN   = resp_ppn_q;
  assign resp_flags = resp_flags_q;
endmodule
